// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, idle-high line.
// Samples receiver_rx at CLKS_PER_BIT clocks per bit (even, 4..256) and writes
// each good byte to an external receive FIFO with a one-cycle strobe.
// Framing errors and FIFO overruns are reported as one-cycle pulses.
// Optional feature macro: UART_RX_MAJORITY_EN -- 2-of-3 majority vote over the
// last three synchronized samples at every sample point.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_tf,
  input  logic       rst_n_tf,
  input  logic       receiver_rx,
  input  logic       rf_full,
  output logic       rf_wr,
  output logic [7:0] rf_din,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic          rx_meta, rx_s, rx_prev;
  logic [1:0]    sync_vld;
  logic          armed;
  logic          bit_smp;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Two-stage synchronizer plus one-cycle delayed copy for edge detection.
  // The synchronizer resets to 1, so its output only reflects the real line
  // after two edges; 'armed' waits for a genuine high on the line so that a
  // line held low across reset release is not mistaken for a falling edge.
  always_ff @(posedge clk_tf or negedge rst_n_tf) begin
    if (!rst_n_tf) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= receiver_rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_s) armed <= 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic       rx_prev2;
  logic [2:0] rx_hist;

  // Third history tap: rx_s two cycles back.
  always_ff @(posedge clk_tf or negedge rst_n_tf) begin
    if (!rst_n_tf) rx_prev2 <= 1'b1;
    else           rx_prev2 <= rx_prev;
  end

  // 2-of-3 vote over current and two previous synchronized samples.
  always_comb begin
    rx_hist = {rx_s, rx_prev, rx_prev2};
    bit_smp = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) |
              (rx_hist[1] & rx_hist[2]);
  end
`else
  // Sample points use the synchronized line directly.
  assign bit_smp = rx_s;
`endif

  // Frame FSM: start detect, mid-bit sampling, stop check, registered outputs.
  always_ff @(posedge clk_tf or negedge rst_n_tf) begin
    if (!rst_n_tf) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      rf_wr       <= 1'b0;
      rf_din      <= 8'h00;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rf_wr       <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
          if (armed && rx_prev && !rx_s) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!bit_smp) begin
              state <= S_DATA;
            end else begin
              // Start bit did not hold until mid-bit: treat as a glitch.
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {bit_smp, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= S_IDLE;
            rx_busy <= 1'b0;
            if (!bit_smp) begin
              frame_err <= 1'b1;
            end else if (rf_full) begin
              overrun_err <= 1'b1;
            end else begin
              rf_wr  <= 1'b1;
              rf_din <= shreg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven and randomized frames against a frame-level
// reference model (byte in, expected event/edge/byte out), plus hand-written
// glitch and reset-mid-frame sequences.
module tb_uart_receiver;

  localparam int CPB      = 16;
  localparam int H        = CPB / 2;
  localparam int STOP_OFS = H + 2 + 9 * CPB;  // t0 -> stop-sample edge
  localparam int K_WR     = 0;
  localparam int K_FERR   = 1;
  localparam int K_OVR    = 2;

  logic       clk_tf = 1'b0;
  logic       rst_n_tf = 1'b0;
  logic       receiver_rx = 1'b1;
  logic       rf_full = 1'b0;
  logic       rf_wr;
  logic [7:0] rf_din;
  logic       frame_err, overrun_err, rx_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk_tf      (clk_tf),
    .rst_n_tf    (rst_n_tf),
    .receiver_rx (receiver_rx),
    .rf_full     (rf_full),
    .rf_wr       (rf_wr),
    .rf_din      (rf_din),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk_tf = ~clk_tf;

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk_tf) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] din;
  } ev_t;

  ev_t evq[$];
  int  busy_cnt = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  function automatic void push_ev(input int k);
    ev_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.din  = rf_din;
    evq.push_back(e);
  endfunction

  // Output monitor, sampled mid-cycle: every high cycle of a pulse is an event.
  always @(negedge clk_tf) begin
    if (rf_wr)       push_ev(K_WR);
    if (frame_err)   push_ev(K_FERR);
    if (overrun_err) push_ev(K_OVR);
    if (rx_busy)     busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_tf);
    #1;
  endtask

  task automatic idle(input int n);
    receiver_rx = 1'b1;
    repeat (n) step();
  endtask

  // One bit period; optionally invert the line for the single cycle that
  // reaches the FSM's synchronized input at this bit's sample edge.
  task automatic drive_bit(input logic b, input int flip_at);
    for (int i = 0; i < CPB; i++) begin
      receiver_rx = (i == flip_at) ? ~b : b;
      step();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic full,
                            input int flip_bit, input int idle_after, output int t0);
    rf_full = full;
    t0 = cyc + 1;
    drive_bit(1'b0, -1);
    for (int k = 0; k < 8; k++) drive_bit(d[k], (k == flip_bit) ? H : -1);
    drive_bit(stop, -1);
    idle(idle_after);
  endtask

  task automatic check_frame(input string name, input int t0, input int kind,
                             input logic [7:0] din);
    ev_t e;
    chk($sformatf("%s count", name), evq.size(), 1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk($sformatf("%s edge", name), e.cyc, t0 + STOP_OFS);
      chk($sformatf("%s kind", name), e.kind, kind);
    end
    chk($sformatf("%s din", name), rf_din, din);
    evq.delete();
  endtask

  task automatic chk_reset_outs(input string name);
    chk($sformatf("%s rf_wr", name), rf_wr, 0);
    chk($sformatf("%s rf_din", name), rf_din, 8'h00);
    chk($sformatf("%s frame_err", name), frame_err, 0);
    chk($sformatf("%s overrun_err", name), overrun_err, 0);
    chk($sformatf("%s rx_busy", name), rx_busy, 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    logic       full;
    int         flip;
    int         idle;
    int         kind;
    logic [7:0] din;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [7:0] d, input logic s,
                              input logic f, input int fl, input int id,
                              input int k, input logic [7:0] dn);
    vec_t v;
    v.name = nm; v.data = d; v.stop = s; v.full = f;
    v.flip = fl; v.idle = id; v.kind = k; v.din = dn;
    return v;
  endfunction

  vec_t vt[7];

  initial begin
    int         t0;
    logic [7:0] last_din;
    logic [7:0] d;
    logic       stop, full;
    int         kind, gap;

    vt[0] = mk("clean_A5", 8'hA5, 1'b1, 1'b0, -1, 4, K_WR,   8'hA5);
    vt[1] = mk("b2b_00",   8'h00, 1'b1, 1'b0, -1, 0, K_WR,   8'h00);
    vt[2] = mk("b2b_FF",   8'hFF, 1'b1, 1'b0, -1, 0, K_WR,   8'hFF);
    vt[3] = mk("b2b_3C",   8'h3C, 1'b1, 1'b0, -1, 4, K_WR,   8'h3C);
    vt[4] = mk("ferr_55",  8'h55, 1'b0, 1'b0, -1, 4, K_FERR, 8'h3C);
    vt[5] = mk("ovr_12",   8'h12, 1'b1, 1'b1, -1, 4, K_OVR,  8'h3C);
`ifdef UART_RX_MAJORITY_EN
    vt[6] = mk("maj_A5",   8'hA5, 1'b1, 1'b0,  3, 4, K_WR,   8'hA5);
`else
    vt[6] = mk("maj_A5",   8'hA5, 1'b1, 1'b0,  3, 4, K_WR,   8'hAD);
`endif

    // Reset state
    repeat (3) @(posedge clk_tf);
    #1;
    chk_reset_outs("reset");
    rst_n_tf = 1'b1;
    idle(6);
    evq.delete();

    // Directed frames
    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].data, vt[i].stop, vt[i].full, vt[i].flip, vt[i].idle, t0);
      check_frame(vt[i].name, t0, vt[i].kind, vt[i].din);
    end
    rf_full  = 1'b0;
    last_din = vt[6].din;

    // Randomized frames against the frame-level model
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      gap  = stop ? $urandom_range(0, 4) : $urandom_range(1, 4);
      if (!stop) kind = K_FERR;
      else if (full) kind = K_OVR;
      else begin
        kind     = K_WR;
        last_din = d;
      end
      send_frame(d, stop, full, -1, gap, t0);
      check_frame($sformatf("rand%0d", i), t0, kind, last_din);
    end
    rf_full = 1'b0;

    // Glitch on the start bit: busy for exactly H cycles, no outputs
    busy_cnt = 0;
    evq.delete();
    receiver_rx = 1'b0;
    repeat (3) step();
    idle(3 * CPB);
    chk("glitch busy_cycles", busy_cnt, H);
    chk("glitch events", evq.size(), 0);
    chk("glitch rx_busy_after", rx_busy, 0);

    // Reset during data bit 4 of 0x0F, line then held low across release
    drive_bit(1'b0, -1);
    for (int k = 0; k < 4; k++) drive_bit(1'b1, -1);
    receiver_rx = 1'b0;
    repeat (H) step();
    chk("midframe rx_busy", rx_busy, 1);
    rst_n_tf = 1'b0;
    #1;
    chk_reset_outs("midreset");
    repeat (4) step();
    rst_n_tf = 1'b1;
    busy_cnt = 0;
    evq.delete();
    repeat (3 * CPB) step();
    chk("held_low busy_cycles", busy_cnt, 0);
    chk("held_low events", evq.size(), 0);
    idle(4);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 4, t0);
    check_frame("after_reset_5A", t0, K_WR, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver. It is the receive-side counterpart of the TX path: 8N1 framing, LSB first, idle-high line. It sits in the `clk_tf` domain, samples `receiver_rx` at `CLKS_PER_BIT` clocks per bit, and writes each good byte to an external receive FIFO through a single-cycle write strobe. Framing errors and FIFO overruns are reported as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 16: `clk_tf` cycles per bit. Must be even and in the range 4..256. `H = CLKS_PER_BIT/2`.
- `clk_tf`  in  1  receive bit clock; all logic is on its rising edge.
- `rst_n_tf`  in  1  reset, asynchronous, active-low.
- `receiver_rx`  in  1  serial line, asynchronous to `clk_tf`, idle high.
- `rf_full`  in  1  receive FIFO full, `clk_tf` domain.
- `rf_wr`  out  1  one-cycle FIFO write strobe.
- `rf_din`  out  8  received byte. Valid while `rf_wr`=1 and held until the next write.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: good byte dropped because `rf_full`=1.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchronizer:** 2-FF synchronizer, both stages reset to 1, output `rx_s`. `rx_prev` holds `rx_s` delayed one cycle and resets to 1.
- **Sample history:** a 3-bit history of `rx_s` is kept for the majority option.
- **Bit counter:** width is `clog2(CLKS_PER_BIT)`.
- **Shift register:** 8 bits. Each sampled data bit enters at bit 7 and the register shifts right, so after 8 bits bit 0 holds the first bit received.
- **IDLE:**
  - When `rx_s`=0 and `rx_prev`=1 (falling edge), go to START with counter=0.
  - A line held low does not retrigger; a new falling edge is required.
- **START:** counter increments each cycle. At the edge where counter==`H`-1, sample the bit:
  - sample 0: go to DATA, counter=0, bit index=0;
  - sample 1 (glitch): go to IDLE with no error and no write.
- **DATA:** at the edge where counter==`CLKS_PER_BIT`-1, sample and shift, set counter=0, and increment the bit index. After the 8th sample, go to STOP.
- **STOP:** at the edge where counter==`CLKS_PER_BIT`-1, sample and return to IDLE:
  - sample 1 and `rf_full`=0: `rf_wr`=1 and `rf_din`=shift register, both registered.
  - sample 1 and `rf_full`=1: `overrun_err`=1, no write, `rf_din` unchanged.
  - sample 0: `frame_err`=1, no write, `rf_din` unchanged.
- **Undefined state encodings:** go to IDLE.
- **Reset values (all outputs):** `rf_wr`=0, `rf_din`=8'h00, `frame_err`=0, `overrun_err`=0, `rx_busy`=0. Internal state is IDLE and the counters are 0.
- **Reset mid-frame:** the partial byte is discarded and no strobe or error is produced. After release the block needs a fresh falling edge.

## Timing
- Let t0 be the first `clk_tf` edge at which `receiver_rx` is low.
  - `rx_s` low is seen by the FSM at edge t0+2, which enters START.
  - Start bit sampled at t0+`H`+2.
  - Data bit k (k=0..7) sampled at t0+`H`+2+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at t0+`H`+2+9·`CLKS_PER_BIT`. `rf_wr`/error pulses are high for exactly the cycle after that edge.
  - For `CLKS_PER_BIT`=16 the stop-sample edge is t0+154.
- The FSM is back in IDLE in the same cycle `rf_wr` is high. A falling edge seen at t0+`H`+3+9·`CLKS_PER_BIT` or later starts the next frame, which allows back-to-back frames.
- `rf_full` is sampled only on the stop-sample edge.
- `rf_wr`, `frame_err` and `overrun_err` are mutually exclusive, and each is at most one cycle per frame.
- `rx_busy` rises with entry to START (visible after t0+2) and falls with return to IDLE.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** every sample point (start, data, stop) uses the majority of the 3-bit `rx_s` history: the current `rx_s` plus the two previous cycles.
  - A single-cycle glitch at the sample point is rejected.
  - Timing edges are unchanged.
- **Undefined:** each sample point uses `rx_s` alone at that edge. The history register is not built.

## Test plan
- **Clean byte:** frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 clk/bit → a single `rf_wr` pulse after edge t0+154, `rf_din`=8'hA5, no errors.
- **Back-to-back:** 0x00, then 0xFF, then 0x3C with 1-bit stop only → three `rf_wr` pulses with `rf_din` 00, FF, 3C in order.
- **Glitch start:** `receiver_rx` low for 3 cycles, then high → return to IDLE, `rx_busy` high ≤`H` cycles, no `rf_wr`, no errors.
- **Framing and overrun:**
  - Byte 0x55 with stop bit 0 → `frame_err` one cycle, no `rf_wr`, `rf_din` unchanged.
  - Byte 0x12 with `rf_full`=1 → `overrun_err` one cycle, no `rf_wr`.
- **Reset mid-frame:** assert `rst_n_tf` during data bit 4 → all outputs at reset values immediately. With the line held low after release, no frame is started until a new falling edge arrives.
- **Majority vote:** with `UART_RX_MAJORITY_EN`, flip `rx_s` for 1 cycle at the bit-3 sample point of 0xA5 → `rf_din`=8'hA5. Without the macro → `rf_din`=8'hAD.
